// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 responder: frame states,
// command opcodes and data-command bit positions.
package tm1638_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_SKIP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_DATA = 2'b01;
  localparam logic [1:0] OP_DISP = 2'b10;
  localparam logic [1:0] OP_ADDR = 2'b11;

  localparam int DC_READ  = 1;
  localparam int DC_FIXED = 2;
  localparam int DC_TEST  = 3;

endpackage

// File: rtl/tm1638_pin_sync.sv
// Three-stage pin synchronizer with registered rise/fall pulses.
module tm1638_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Reset to 0 so a pin held low through reset never produces a fall;
  // it must be seen high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (en) begin
      s1   <= pin;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign level = s3;

endmodule

// File: rtl/tm1638_resp.sv
// TM1638 device-side responder: decodes STB/CLK/DIO frames, holds display
// RAM and control state, and shifts key-scan data out on read frames.
module tm1638_resp
  import tm1638_pkg::*;
#(
  parameter int C_RAM_DEPTH = 16
) (
  input  logic        CK_i,
  input  logic        RST_i,
  input  logic        EN_CK_i,
  input  logic        STB_i,
  input  logic        SCLK_i,
  input  logic        DIO_i,
  output logic        DIO_o,
  output logic        DIO_OE_o,
  input  logic [31:0] KEY_i,
  input  logic [3:0]  RAM_RD_ADR_i,
  output logic [7:0]  RAM_RD_DAT_o,
  output logic        DISP_ON_o,
  output logic [2:0]  BRIGHT_o,
  output logic        TEST_o,
  output logic        WR_STB_o,
  output logic [2:0]  DBG_STATE_o
);

  logic stb_lvl, stb_rise, stb_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic dio_lvl, dio_rise, dio_fall;

  tm1638_pin_sync u_stb  (.clk(CK_i), .rst(RST_i), .en(EN_CK_i), .pin(STB_i),
                          .level(stb_lvl), .rise(stb_rise), .fall(stb_fall));
  tm1638_pin_sync u_sclk (.clk(CK_i), .rst(RST_i), .en(EN_CK_i), .pin(SCLK_i),
                          .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  tm1638_pin_sync u_dio  (.clk(CK_i), .rst(RST_i), .en(EN_CK_i), .pin(DIO_i),
                          .level(dio_lvl), .rise(dio_rise), .fall(dio_fall));

  logic unused_ok;
  assign unused_ok = ^{stb_lvl, sclk_lvl, dio_rise, dio_fall};

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [3:0]  addr;
  logic        fixed;
  logic        rd_mode;
  logic [31:0] key_sh;
  logic [4:0]  key_idx;
  logic [7:0]  ram [C_RAM_DEPTH];

  logic [7:0] rx_byte;
  logic       byte_done;

  // Newest bit enters at the MSB, so after 8 bits the first bit is bit 0.
  assign rx_byte   = {dio_lvl, shreg};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) &&
                     ((state == ST_CMD) || (state == ST_WDATA));
  assign DBG_STATE_o = state;

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      addr         <= '0;
      fixed        <= 1'b0;
      rd_mode      <= 1'b0;
      key_sh       <= '0;
      key_idx      <= '0;
      DIO_o        <= 1'b1;
      DIO_OE_o     <= 1'b0;
      DISP_ON_o    <= 1'b0;
      BRIGHT_o     <= '0;
      TEST_o       <= 1'b0;
      WR_STB_o     <= 1'b0;
      RAM_RD_DAT_o <= '0;
      for (int i = 0; i < C_RAM_DEPTH; i++) ram[i] <= '0;
    end else if (EN_CK_i) begin
      WR_STB_o     <= 1'b0;
      RAM_RD_DAT_o <= ram[RAM_RD_ADR_i];

      if (stb_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && ((state == ST_CMD) || (state == ST_WDATA))) begin
        shreg   <= rx_byte[7:1];
        bit_cnt <= bit_cnt + 3'd1;
      end

      case (state)
        ST_IDLE: if (stb_fall) state <= ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte[7:6])
              OP_DATA: begin
                fixed   <= rx_byte[DC_FIXED];
                TEST_o  <= rx_byte[DC_TEST];
                rd_mode <= rx_byte[DC_READ];
                if (rx_byte[DC_READ]) begin
                  key_sh  <= KEY_i;
                  key_idx <= '0;
                  state   <= ST_RDATA;
                end else begin
                  state <= ST_SKIP;
                end
              end
              OP_DISP: begin
                DISP_ON_o <= rx_byte[3];
                BRIGHT_o  <= rx_byte[2:0];
                state     <= ST_SKIP;
              end
              OP_ADDR: begin
                addr  <= rx_byte[3:0];
                state <= rd_mode ? ST_SKIP : ST_WDATA;
              end
              default: state <= ST_SKIP;
            endcase
          end
        end
        ST_WDATA: begin
          if (byte_done) begin
            ram[addr] <= rx_byte;
            WR_STB_o  <= 1'b1;
            if (!fixed) addr <= addr + 4'd1;
          end
        end
        ST_RDATA: begin
          // After bit 31 goes out, recapture so the next fall sends bit 0 again.
          if (sclk_fall) begin
            DIO_OE_o <= 1'b1;
            DIO_o    <= key_sh[0];
            if (key_idx == 5'd31) begin
              key_sh  <= KEY_i;
              key_idx <= '0;
            end else begin
              key_sh  <= {1'b0, key_sh[31:1]};
              key_idx <= key_idx + 5'd1;
            end
          end
        end
        default: ;
      endcase

      // Applied last so a byte finishing on the same cycle still completes.
      if (stb_rise) begin
        state    <= ST_IDLE;
        DIO_OE_o <= 1'b0;
        DIO_o    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tm1638_resp.sv
// Directed bench for tm1638_resp: bit-banged master frames, a behavioural
// RAM/control model and a queue of expected DIO read bits.
module tb_tm1638_resp;

  logic        clk = 1'b0;
  logic        rst, en, stb, sclk, dio_in;
  logic        dio_out, dio_oe;
  logic [31:0] key;
  logic [3:0]  rd_adr;
  logic [7:0]  rd_dat;
  logic        disp_on, test_bit, wr_stb;
  logic [2:0]  bright, dbg_state;

  tm1638_resp dut (
    .CK_i(clk), .RST_i(rst), .EN_CK_i(en), .STB_i(stb), .SCLK_i(sclk),
    .DIO_i(dio_in), .DIO_o(dio_out), .DIO_OE_o(dio_oe), .KEY_i(key),
    .RAM_RD_ADR_i(rd_adr), .RAM_RD_DAT_o(rd_dat), .DISP_ON_o(disp_on),
    .BRIGHT_o(bright), .TEST_o(test_bit), .WR_STB_o(wr_stb),
    .DBG_STATE_o(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;

  logic [0:0] exp_q[$];

  logic [7:0] m_ram [16];
  logic [3:0] m_addr;
  logic       m_fixed, m_rd, m_test, m_disp, m_wst;
  logic [2:0] m_bright;
  int         m_wr;

  always @(negedge clk) if (wr_stb) wr_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sbit(input logic b);
    @(negedge clk);
    sclk = 1'b0;
    dio_in = b;
    repeat (6) @(negedge clk);
    sclk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) sbit(b[i]);
  endtask

  task automatic stb_low();
    @(negedge clk);
    stb = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic stb_high();
    @(negedge clk);
    stb = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit first);
    if (first) begin
      m_wst = 1'b0;
      case (b[7:6])
        2'b01: begin m_fixed = b[2]; m_test = b[3]; m_rd = b[1]; end
        2'b10: begin m_disp = b[3]; m_bright = b[2:0]; end
        2'b11: begin m_addr = b[3:0]; m_wst = !m_rd; end
        default: ;
      endcase
    end else if (m_wst) begin
      m_ram[m_addr] = b;
      m_wr++;
      if (!m_fixed) m_addr = m_addr + 4'd1;
    end
  endtask

  task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    logic [7:0] bb [5];
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3; bb[4] = b4;
    stb_low();
    for (int k = 0; k < n; k++) begin
      send_bits(bb[k], 8);
      model_byte(bb[k], k == 0);
    end
    stb_high();
  endtask

  task automatic check_ram();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_adr = 4'(a);
      @(negedge clk);
      check($sformatf("ram%0d", a), {24'd0, rd_dat}, {24'd0, m_ram[a]});
    end
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, "_disp"}, {31'd0, disp_on}, {31'd0, m_disp});
    check({tag, "_bright"}, {29'd0, bright}, {29'd0, m_bright});
    check({tag, "_test"}, {31'd0, test_bit}, {31'd0, m_test});
    check({tag, "_wr_cnt"}, wr_seen, m_wr);
  endtask

  task automatic read_bits(input int n);
    logic [0:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      repeat (6) @(negedge clk);
      if (exp_q.size() == 0) begin
        check("dio_q_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("dio_bit%0d", i), {31'd0, dio_out}, {31'd0, e});
      end
      check("dio_oe", {31'd0, dio_oe}, 32'd1);
      sclk = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] k1, k2;
    int n;
    rst = 1'b1; en = 1'b1; stb = 1'b1; sclk = 1'b1; dio_in = 1'b1;
    key = '0; rd_adr = '0;
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_addr = '0; m_fixed = 0; m_rd = 0; m_test = 0; m_disp = 0; m_wst = 0;
    m_bright = '0; m_wr = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Reset state
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_oe", {31'd0, dio_oe}, 32'd0);
    check("rst_dio", {31'd0, dio_out}, 32'd1);
    check_ctrl("rst");
    check_ram();

    // Auto-increment write from address 0
    frame(1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    frame(4, 8'hC0, 8'h3F, 8'h06, 8'h5B, 8'h00);
    check_ctrl("auto");
    check_ram();

    // Fixed mode at address 15: second byte overwrites, no wrap
    frame(1, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00);
    frame(3, 8'hCF, 8'hAA, 8'h55, 8'h00, 8'h00);
    check_ctrl("fixed");
    check_ram();

    // Auto mode wrapping 14,15,0,1
    frame(1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    frame(5, 8'hCE, 8'h11, 8'h22, 8'h33, 8'h44);
    check_ctrl("wrap");
    check_ram();

    // Key read: 32 bits of first capture, then restart on a fresh capture
    k1 = 32'h8000_0001;
    k2 = 32'h0000_00A5;
    key = k1;
    stb_low();
    send_bits(8'h42, 8);
    model_byte(8'h42, 1'b1);
    key = k2;
    for (int i = 0; i < 32; i++) exp_q.push_back(k1[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(k2[i]);
    read_bits(40);
    check("dio_q_drained", exp_q.size(), 0);
    @(negedge clk);
    stb = 1'b1;
    n = 0;
    while (dio_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("oe_drop_cycles", n, 4);
    check("idle_dio", {31'd0, dio_out}, 32'd1);
    repeat (10) @(negedge clk);
    check_ctrl("read");

    // Display control, then a partial command byte
    frame(1, 8'h8C, 8'h00, 8'h00, 8'h00, 8'h00);
    check_ctrl("disp");
    stb_low();
    check("cmd_state", {29'd0, dbg_state}, 32'd1);
    send_bits(8'hC3, 5);
    stb_high();
    check("partial_idle", {29'd0, dbg_state}, 32'd0);
    check_ctrl("partial");

    // Partial trailing data byte is discarded
    frame(1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    stb_low();
    send_bits(8'hC5, 8);
    model_byte(8'hC5, 1'b1);
    send_bits(8'h77, 8);
    model_byte(8'h77, 1'b0);
    send_bits(8'hFF, 3);
    stb_high();
    check_ctrl("partial_data");
    check_ram();

    // Test bit, then an unassigned opcode that must change nothing
    frame(1, 8'h48, 8'h00, 8'h00, 8'h00, 8'h00);
    frame(1, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00);
    check_ctrl("test_nop");

    // Clock enable low: a display-off frame must be ignored
    en = 1'b0;
    stb_low();
    send_bits(8'h80, 8);
    stb_high();
    en = 1'b1;
    repeat (10) @(negedge clk);
    check_ctrl("en_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
